// File: rtl/pes_cla_seq_adder_if.sv
// Operand/result handshake bundle for the nibble-serial CLA adder.
// The master drives operands and consumes results; the slave is the adder.
interface pes_cla_seq_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_pg;
   logic             out_gg;
   logic             out_ovf;

   modport master (
      output in_valid, in_a, in_b, in_cin, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_pg, out_gg, out_ovf
   );

   modport slave (
      input  in_valid, in_a, in_b, in_cin, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_pg, out_gg, out_ovf
   );
endinterface

// File: rtl/pes_cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder that reuses one 4-bit carry-lookahead slice,
// one nibble per clock LSB first, with valid/ready on both sides.
module pes_cla_adder (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       Cin,
   output logic [3:0] S,
   output logic       Cout,
   output logic       PG,
   output logic       GG
);
   logic [3:0] p;
   logic [3:0] g;
   logic [3:0] c;

   assign p = A ^ B;
   assign g = A & B;

   // Carries are flattened lookahead terms rather than a ripple chain.
   assign c[0] = Cin;
   assign c[1] = g[0] | (p[0] & Cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Cin);

   assign PG   = &p;
   assign GG   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   assign Cout = GG | (PG & Cin);
   assign S    = p ^ c;
endmodule

module pes_cla_seq_adder #(
   parameter int WIDTH = 16
) (
   input logic                  clk,
   input logic                  rst_n,
   pes_cla_seq_adder_if.slave   bus
);
   localparam int NIBBLES = WIDTH / 4;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               carry_q, carry_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               pg_acc_q, pg_acc_d;
   logic               gg_acc_q, gg_acc_d;
   logic [WIDTH-1:0]   out_sum_q, out_sum_d;
   logic               out_cout_q, out_cout_d;
   logic               out_pg_q, out_pg_d;
   logic               out_gg_q, out_gg_d;
   logic               out_ovf_q, out_ovf_d;

   logic [3:0]         slice_a;
   logic [3:0]         slice_b;
   logic [3:0]         slice_s;
   logic               slice_cout;
   logic               slice_pg;
   logic               slice_gg;

   assign slice_a = a_q[4*idx_q +: 4];
   assign slice_b = b_q[4*idx_q +: 4];

   pes_cla_adder u_slice (
      .S    (slice_s),
      .Cout (slice_cout),
      .PG   (slice_pg),
      .GG   (slice_gg),
      .A    (slice_a),
      .B    (slice_b),
      .Cin  (carry_q)
   );

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      sum_d      = sum_q;
      carry_d    = carry_q;
      idx_d      = idx_q;
      pg_acc_d   = pg_acc_q;
      gg_acc_d   = gg_acc_q;
      out_sum_d  = out_sum_q;
      out_cout_d = out_cout_q;
      out_pg_d   = out_pg_q;
      out_gg_d   = out_gg_q;
      out_ovf_d  = out_ovf_q;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d      = bus.in_a;
               b_d      = bus.in_b;
               carry_d  = bus.in_cin;
               idx_d    = '0;
               pg_acc_d = 1'b1;
               gg_acc_d = 1'b0;
               state_d  = RUN;
            end
         end
         RUN: begin
            sum_d[4*idx_q +: 4] = slice_s;
            carry_d  = slice_cout;
            pg_acc_d = pg_acc_q & slice_pg;
            // The new nibble is more significant than everything accumulated so far.
            gg_acc_d = slice_gg | (slice_pg & gg_acc_q);
            idx_d    = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(NIBBLES - 1)) begin
               idx_d      = '0;
               state_d    = DONE;
               out_sum_d  = sum_d;
               out_cout_d = slice_cout;
               out_pg_d   = pg_acc_d;
               out_gg_d   = gg_acc_d;
               out_ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         sum_q      <= '0;
         carry_q    <= 1'b0;
         idx_q      <= '0;
         pg_acc_q   <= 1'b0;
         gg_acc_q   <= 1'b0;
         out_sum_q  <= '0;
         out_cout_q <= 1'b0;
         out_pg_q   <= 1'b0;
         out_gg_q   <= 1'b0;
         out_ovf_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         sum_q      <= sum_d;
         carry_q    <= carry_d;
         idx_q      <= idx_d;
         pg_acc_q   <= pg_acc_d;
         gg_acc_q   <= gg_acc_d;
         out_sum_q  <= out_sum_d;
         out_cout_q <= out_cout_d;
         out_pg_q   <= out_pg_d;
         out_gg_q   <= out_gg_d;
         out_ovf_q  <= out_ovf_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.out_sum   = out_sum_q;
   assign bus.out_cout  = out_cout_q;
   assign bus.out_pg    = out_pg_q;
   assign bus.out_gg    = out_gg_q;
   assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_pes_cla_seq_adder.sv
// Bench for the nibble-serial CLA adder: directed corner cases, backpressure,
// mid-operation reset and random operands checked against an arithmetic model.
module tb_pes_cla_seq_adder;
   localparam int WIDTH = 16;
   localparam int NIBBLES = WIDTH / 4;

   logic clk;
   logic rst_n;
   int   totalChecks;
   int   badChecks;

   pes_cla_seq_adder_if #(.WIDTH(WIDTH)) bus ();

   pes_cla_seq_adder #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Last-resort guard so a stuck design still ends the run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      totalChecks++;
      if (got !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Drives one operation from accept to release; holdCycles of backpressure
   // are applied with junk on the input side to prove it is ignored.
   task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic cin, input int holdCycles);
      logic [WIDTH:0]   full;
      logic [WIDTH:0]   noCin;
      logic [WIDTH-1:0] expSum;
      logic             expCout, expPg, expGg, expOvf;
      int               waited;
      int               latency;

      full    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      noCin   = {1'b0, a} + {1'b0, b};
      expSum  = full[WIDTH-1:0];
      expCout = full[WIDTH];
      expGg   = noCin[WIDTH];
      expPg   = &(a ^ b);
      expOvf  = (a[WIDTH-1] == b[WIDTH-1]) && (expSum[WIDTH-1] != a[WIDTH-1]);

      waited = 0;
      while (bus.in_ready !== 1'b1 && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      checkOutput("in_ready_before_accept", {31'd0, bus.in_ready}, 32'd1);

      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_cin   = cin;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_a     = WIDTH'($urandom);
      bus.in_b     = WIDTH'($urandom);
      bus.in_cin   = 1'($urandom);

      latency = 0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (bus.out_valid === 1'b1) begin
            latency = n;
            break;
         end
      end
      checkOutput("latency", latency, NIBBLES);
      checkOutput("sum", {16'd0, bus.out_sum}, {16'd0, expSum});
      checkOutput("cout", {31'd0, bus.out_cout}, {31'd0, expCout});
      checkOutput("pg", {31'd0, bus.out_pg}, {31'd0, expPg});
      checkOutput("gg", {31'd0, bus.out_gg}, {31'd0, expGg});
      checkOutput("ovf", {31'd0, bus.out_ovf}, {31'd0, expOvf});
      checkOutput("cout_invariant", {31'd0, bus.out_cout},
                  {31'd0, bus.out_gg | (bus.out_pg & cin)});

      for (int h = 0; h < holdCycles; h++) begin
         bus.in_valid = ~bus.in_valid;
         bus.in_a     = WIDTH'($urandom);
         @(posedge clk); #1;
         checkOutput("hold_valid", {31'd0, bus.out_valid}, 32'd1);
         checkOutput("hold_sum", {16'd0, bus.out_sum}, {16'd0, expSum});
         checkOutput("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      checkOutput("release_valid", {31'd0, bus.out_valid}, 32'd0);
      checkOutput("release_in_ready", {31'd0, bus.in_ready}, 32'd1);
      checkOutput("kept_sum", {16'd0, bus.out_sum}, {16'd0, expSum});
      @(posedge clk); #1;
      checkOutput("no_second_result", {31'd0, bus.out_valid}, 32'd0);
   endtask

   initial begin
      totalChecks   = 0;
      badChecks     = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_a      = 16'hFFFF;
      bus.in_b      = 16'hFFFF;
      bus.in_cin    = 1'b1;
      bus.out_ready = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
      checkOutput("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
      checkOutput("reset_sum", {16'd0, bus.out_sum}, 32'd0);
      checkOutput("reset_flags", {28'd0, bus.out_cout, bus.out_pg, bus.out_gg, bus.out_ovf}, 32'd0);
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      $display("[TB] directed corner cases");
      applyStimulus(16'h0001, 16'h0000, 1'b0, 0);
      applyStimulus(16'hFFFF, 16'h0001, 1'b0, 0);
      applyStimulus(16'h7FFF, 16'h0001, 1'b0, 0);
      applyStimulus(16'hA5A5, 16'h5A5A, 1'b1, 0);
      applyStimulus(16'h8000, 16'h8000, 1'b0, 1);

      $display("[TB] backpressure");
      applyStimulus(16'h1234, 16'h1111, 1'b0, 5);

      $display("[TB] reset during RUN");
      bus.in_a     = 16'hFFFF;
      bus.in_b     = 16'hFFFF;
      bus.in_cin   = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      checkOutput("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      checkOutput("midrst_sum", {16'd0, bus.out_sum}, 32'd0);
      checkOutput("midrst_flags", {28'd0, bus.out_cout, bus.out_pg, bus.out_gg, bus.out_ovf}, 32'd0);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         checkOutput("midrst_no_valid", {31'd0, bus.out_valid}, 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         checkOutput("post_rst_no_valid", {31'd0, bus.out_valid}, 32'd0);
      end
      applyStimulus(16'h0F0F, 16'h00F1, 1'b0, 0);

      $display("[TB] random operands");
      for (int t = 0; t < 40; t++) begin
         applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                       int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end
endmodule
